// File: rtl/dcache_control.sv
// dcache_control: control FSM for the N-way set-associative write-back data
// cache. Sits between the cache datapath and the DFP (memory) port, sequencing
// hit checks, CPU write hits, dirty-victim writeback and line fill.
//
// State table:
//   state        | meaning
//   IDLE         | waiting for a request; arms all ways for a tag/data read
//   CHECK        | tag compare result valid; hit completes, miss starts refill
//   WRITEBACK    | dirty victim line written to DFP, held until dfp_resp
//   FETCH        | new line read from DFP; filled into victim way on dfp_resp
//   FETCH_WAIT   | re-read the set so the following CHECK sees the new line
//
// Optional feature: define DCACHE_PERF_CNT_EN to build saturating hit, miss
// and writeback counters. Without it the counter ports are tied to zero and
// no counter flops exist.
module dcache_control #(
    parameter int WAYS      = 4,
    parameter int CNT_WIDTH = 32,
    localparam int WIDX     = $clog2(WAYS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cache_read_request,
    input  logic                 cache_write_request,
    input  logic                 cache_hit,
    input  logic [WIDX-1:0]      hit_way,
    input  logic [WIDX-1:0]      victim_way,
    input  logic                 victim_valid,
    input  logic                 victim_dirty,
    input  logic                 dfp_resp,
    output logic                 ufp_resp,
    output logic                 dfp_read,
    output logic                 dfp_write,
    output logic [WAYS-1:0]      tag_array_csb0,
    output logic [WAYS-1:0]      data_array_csb0,
    output logic [WAYS-1:0]      valid_array_csb0,
    output logic [WAYS-1:0]      dirty_array_csb0,
    output logic                 write_from_mem,
    output logic                 write_from_cpu,
    output logic                 ready,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count,
    output logic [CNT_WIDTH-1:0] writeback_count
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_CHECK      = 3'd1,
        S_WRITEBACK  = 3'd2,
        S_FETCH      = 3'd3,
        S_FETCH_WAIT = 3'd4
    } state_e;

    state_e state_q, state_d;

    logic            request;
    logic [WAYS-1:0] way_one;
    logic [WAYS-1:0] hit_mask_n;
    logic [WAYS-1:0] victim_mask_n;

    // A simultaneous read and write is handled as a write.
    assign request       = cache_read_request | cache_write_request;
    assign way_one       = {{(WAYS-1){1'b0}}, 1'b1};
    assign hit_mask_n    = ~(way_one << hit_way);
    assign victim_mask_n = ~(way_one << victim_way);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (request) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (!request) begin
                    state_d = S_IDLE;
                end else if (cache_hit) begin
                    // Reads keep streaming while a request is present; a
                    // write hit always returns to IDLE.
                    state_d = cache_write_request ? S_IDLE : S_CHECK;
                end else if (victim_valid && victim_dirty) begin
                    state_d = S_WRITEBACK;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WRITEBACK: begin
                if (dfp_resp) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (dfp_resp) state_d = S_FETCH_WAIT;
            end
            S_FETCH_WAIT: begin
                state_d = S_CHECK;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from state and inputs.
    always_comb begin
        ufp_resp         = 1'b0;
        dfp_read         = 1'b0;
        dfp_write        = 1'b0;
        write_from_mem   = 1'b0;
        write_from_cpu   = 1'b0;
        ready            = 1'b0;
        tag_array_csb0   = '1;
        data_array_csb0  = '1;
        valid_array_csb0 = '1;
        dirty_array_csb0 = '1;
        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
                if (request) begin
                    tag_array_csb0   = '0;
                    data_array_csb0  = '0;
                    valid_array_csb0 = '0;
                    dirty_array_csb0 = '0;
                end
            end
            S_CHECK: begin
                if (!request) begin
                    ready = 1'b1;
                end else if (cache_hit) begin
                    ufp_resp = 1'b1;
                    if (cache_write_request) begin
                        write_from_cpu   = 1'b1;
                        data_array_csb0  = hit_mask_n;
                        dirty_array_csb0 = hit_mask_n;
                    end else begin
                        ready            = 1'b1;
                        tag_array_csb0   = '0;
                        data_array_csb0  = '0;
                        valid_array_csb0 = '0;
                        dirty_array_csb0 = '0;
                    end
                end
            end
            S_WRITEBACK: begin
                dfp_write = 1'b1;
            end
            S_FETCH: begin
                dfp_read = 1'b1;
                if (dfp_resp) begin
                    write_from_mem   = 1'b1;
                    tag_array_csb0   = victim_mask_n;
                    data_array_csb0  = victim_mask_n;
                    valid_array_csb0 = victim_mask_n;
                    dirty_array_csb0 = victim_mask_n;
                end
            end
            S_FETCH_WAIT: begin
                tag_array_csb0   = '0;
                data_array_csb0  = '0;
                valid_array_csb0 = '0;
                dirty_array_csb0 = '0;
            end
            default: begin
            end
        endcase
    end

`ifdef DCACHE_PERF_CNT_EN
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic                 refill_q, refill_d;
    logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;
    logic [CNT_WIDTH-1:0] wb_cnt_q, wb_cnt_d;
    logic                 hit_event, miss_event, wb_event;

    // The CHECK right after a refill is a guaranteed hit and is not a real
    // CPU hit, so it is excluded from hit_count.
    assign refill_d   = (state_q == S_FETCH_WAIT);
    assign hit_event  = (state_q == S_CHECK) && request && cache_hit && !refill_q;
    assign miss_event = (state_q == S_CHECK) && request && !cache_hit;
    assign wb_event   = miss_event && victim_valid && victim_dirty;

    // Saturating counter increments.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        wb_cnt_d   = wb_cnt_q;
        if (hit_event && hit_cnt_q != CNT_MAX)   hit_cnt_d  = hit_cnt_q + CNT_WIDTH'(1);
        if (miss_event && miss_cnt_q != CNT_MAX) miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
        if (wb_event && wb_cnt_q != CNT_MAX)     wb_cnt_d   = wb_cnt_q + CNT_WIDTH'(1);
    end

    // Counter and refill-flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            refill_q   <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            refill_q   <= refill_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            wb_cnt_q   <= wb_cnt_d;
        end
    end

    assign hit_count       = hit_cnt_q;
    assign miss_count      = miss_cnt_q;
    assign writeback_count = wb_cnt_q;
`else
    assign hit_count       = '0;
    assign miss_count      = '0;
    assign writeback_count = '0;
`endif

endmodule

// File: tb/tb_dcache_control.sv
// Testbench for dcache_control. Transactions (read-hit bursts, write hits,
// clean and dirty misses, reset during a fill) are expanded into a
// cycle-by-cycle plan of inputs and expected outputs; one process replays
// the plan and compares every output on every cycle.
module tb_dcache_control;

    localparam int WAYS = 4;
    localparam int CW   = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cache_read_request, cache_write_request, cache_hit;
    logic [1:0]    hit_way, victim_way;
    logic          victim_valid, victim_dirty, dfp_resp;
    logic          ufp_resp, dfp_read, dfp_write, write_from_mem, write_from_cpu, ready;
    logic [3:0]    tag_array_csb0, data_array_csb0, valid_array_csb0, dirty_array_csb0;
    logic [CW-1:0] hit_count, miss_count, writeback_count;

    dcache_control #(.WAYS(WAYS), .CNT_WIDTH(CW)) dut (
        .clk                (clk),
        .rst                (rst),
        .cache_read_request (cache_read_request),
        .cache_write_request(cache_write_request),
        .cache_hit          (cache_hit),
        .hit_way            (hit_way),
        .victim_way         (victim_way),
        .victim_valid       (victim_valid),
        .victim_dirty       (victim_dirty),
        .dfp_resp           (dfp_resp),
        .ufp_resp           (ufp_resp),
        .dfp_read           (dfp_read),
        .dfp_write          (dfp_write),
        .tag_array_csb0     (tag_array_csb0),
        .data_array_csb0    (data_array_csb0),
        .valid_array_csb0   (valid_array_csb0),
        .dirty_array_csb0   (dirty_array_csb0),
        .write_from_mem     (write_from_mem),
        .write_from_cpu     (write_from_cpu),
        .ready              (ready),
        .hit_count          (hit_count),
        .miss_count         (miss_count),
        .writeback_count    (writeback_count)
    );

    always #5 clk = ~clk;

    // One planned cycle: inputs to apply and outputs the spec requires.
    typedef struct packed {
        logic        rst;
        logic        chk;
        logic        rd;
        logic        wr;
        logic        hit;
        logic [1:0]  hw;
        logic [1:0]  vw;
        logic        vv;
        logic        vd;
        logic        dresp;
        logic [21:0] exp_o;
        logic        ih;
        logic        im;
        logic        iw;
    } cyc_t;

    cyc_t q[$];

    int checks   = 0;
    int failures = 0;

    // Output vector: {ufp, dfp_read, dfp_write, ready, wfm, wfc, tag, data, valid, dirty}
    function automatic logic [21:0] ex(input logic u, input logic dr, input logic dw,
                                       input logic rdy, input logic wm, input logic wc,
                                       input logic [3:0] t, input logic [3:0] d,
                                       input logic [3:0] v, input logic [3:0] y);
        return {u, dr, dw, rdy, wm, wc, t, d, v, y};
    endfunction

    function automatic logic [3:0] way_n(input logic [1:0] w);
        logic [3:0] m;
        m = 4'b0001 << w;
        return ~m;
    endfunction

    // Idle cycle with junk on the inputs that only matter in CHECK/FETCH.
    function automatic cyc_t blank();
        cyc_t c;
        c.rst   = 1'b0;
        c.chk   = 1'b1;
        c.rd    = 1'b0;
        c.wr    = 1'b0;
        c.hit   = 1'($urandom_range(1));
        c.hw    = 2'($urandom_range(3));
        c.vw    = 2'($urandom_range(3));
        c.vv    = 1'($urandom_range(1));
        c.vd    = 1'($urandom_range(1));
        c.dresp = 1'b0;
        c.exp_o = ex(0, 0, 0, 1, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF);
        c.ih    = 1'b0;
        c.im    = 1'b0;
        c.iw    = 1'b0;
        return c;
    endfunction

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) q.push_back(blank());
    endtask

    task automatic req_cycle(input logic rd, input logic wr, input logic [1:0] vw);
        cyc_t c;
        c = blank();
        c.rd = rd; c.wr = wr; c.vw = vw;
        c.exp_o = ex(0, 0, 0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        q.push_back(c);
    endtask

    task automatic read_burst(input int n);
        cyc_t c;
        req_cycle(1'b1, 1'b0, 2'($urandom_range(3)));
        for (int i = 0; i < n; i++) begin
            c = blank();
            c.rd = 1'b1; c.hit = 1'b1;
            c.exp_o = ex(1, 0, 0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
            c.ih = 1'b1;
            q.push_back(c);
        end
        gap(1 + int'($urandom_range(2)));
    endtask

    function automatic cyc_t whit(input logic [1:0] way, input logic [1:0] vw, input logic counted);
        cyc_t c;
        c = blank();
        c.wr = 1'b1; c.rd = 1'($urandom_range(1)); c.hit = 1'b1; c.hw = way; c.vw = vw;
        c.exp_o = ex(1, 0, 0, 0, 0, 1, 4'hF, way_n(way), 4'hF, way_n(way));
        c.ih = counted;
        return c;
    endfunction

    task automatic write_hit(input logic [1:0] way);
        req_cycle(1'($urandom_range(1)), 1'b1, 2'($urandom_range(3)));
        q.push_back(whit(way, 2'($urandom_range(3)), 1'b1));
        gap(1 + int'($urandom_range(2)));
    endtask

    task automatic miss(input logic wr, input logic [1:0] v, input logic vv, input logic vd,
                        input int l1, input int l2);
        cyc_t c;
        logic rd;
        rd = wr ? 1'($urandom_range(1)) : 1'b1;
        req_cycle(rd, wr, v);
        c = blank();
        c.rd = rd; c.wr = wr; c.hit = 1'b0; c.vw = v; c.vv = vv; c.vd = vd;
        c.exp_o = ex(0, 0, 0, 0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF);
        c.im = 1'b1; c.iw = vv & vd;
        q.push_back(c);
        if (vv && vd) begin
            for (int i = 0; i < l1; i++) begin
                c = blank();
                c.rd = rd; c.wr = wr; c.vw = v; c.dresp = (i == l1 - 1);
                c.exp_o = ex(0, 0, 1, 0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF);
                q.push_back(c);
            end
        end
        for (int i = 0; i < l2; i++) begin
            c = blank();
            c.rd = rd; c.wr = wr; c.vw = v; c.dresp = (i == l2 - 1);
            if (i == l2 - 1) c.exp_o = ex(0, 1, 0, 0, 1, 0, way_n(v), way_n(v), way_n(v), way_n(v));
            else             c.exp_o = ex(0, 1, 0, 0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF);
            q.push_back(c);
        end
        c = blank();
        c.rd = rd; c.wr = wr; c.vw = v;
        c.exp_o = ex(0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
        q.push_back(c);
        if (wr) begin
            q.push_back(whit(v, v, 1'b0));
        end else begin
            c = blank();
            c.rd = 1'b1; c.hit = 1'b1; c.hw = v; c.vw = v;
            c.exp_o = ex(1, 0, 0, 1, 0, 0, 4'h0, 4'h0, 4'h0, 4'h0);
            q.push_back(c);
        end
        gap(1 + int'($urandom_range(2)));
    endtask

    task automatic reset_mid_fetch();
        cyc_t c;
        req_cycle(1'b1, 1'b0, 2'd2);
        c = blank();
        c.rd = 1'b1; c.hit = 1'b0; c.vw = 2'd2; c.vv = 1'b1; c.vd = 1'b0;
        c.exp_o = ex(0, 0, 0, 0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF);
        c.im = 1'b1;
        q.push_back(c);
        for (int i = 0; i < 3; i++) begin
            c = blank();
            c.rd = 1'b1; c.vw = 2'd2; c.rst = (i == 2);
            c.exp_o = ex(0, 1, 0, 0, 0, 0, 4'hF, 4'hF, 4'hF, 4'hF);
            q.push_back(c);
        end
        gap(2);
    endtask

    logic [21:0]   got;
    logic [3*CW-1:0] cnt_got, cnt_exp;
    logic [CW-1:0] m_hit = '0, m_miss = '0, m_wb = '0;
    int            dir_end;
    int            obs_ufp = 0, obs_dr = 0, obs_dw = 0;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v, input logic inc);
        if (inc && v != {CW{1'b1}}) return v + CW'(1);
        return v;
    endfunction

    initial begin
        cyc_t c;
        // Power-on reset: outputs undefined until the first edge.
        for (int i = 0; i < 2; i++) begin
            c = blank(); c.rst = 1'b1; c.chk = 1'b0; q.push_back(c);
        end
        gap(1);
        read_burst(3);
        write_hit(2'd2);
        miss(1'b0, 2'd1, 1'b1, 1'b0, 0, 5);
        miss(1'b1, 2'd3, 1'b1, 1'b1, 3, 2);
        dir_end = q.size();
        reset_mid_fetch();
        for (int t = 0; t < 160; t++) begin
            case ($urandom_range(3))
                0: read_burst(1 + int'($urandom_range(3)));
                1: write_hit(2'($urandom_range(3)));
                default: miss(1'($urandom_range(1)), 2'($urandom_range(3)),
                              1'($urandom_range(1)), 1'($urandom_range(1)),
                              1 + int'($urandom_range(5)), 1 + int'($urandom_range(5)));
            endcase
        end
        reset_mid_fetch();

        foreach (q[i]) begin
            @(negedge clk);
            rst                 = q[i].rst;
            cache_read_request  = q[i].rd;
            cache_write_request = q[i].wr;
            cache_hit           = q[i].hit;
            hit_way             = q[i].hw;
            victim_way          = q[i].vw;
            victim_valid        = q[i].vv;
            victim_dirty        = q[i].vd;
            dfp_resp            = q[i].dresp;
            #1;
            if (q[i].chk) begin
                got = {ufp_resp, dfp_read, dfp_write, ready, write_from_mem, write_from_cpu,
                       tag_array_csb0, data_array_csb0, valid_array_csb0, dirty_array_csb0};
                checks++;
                if (got !== q[i].exp_o) begin
                    failures++;
                    $display("FAIL outputs cycle=%0d got=%h expected=%h", i, got, q[i].exp_o);
                end
                cnt_got = {hit_count, miss_count, writeback_count};
`ifdef DCACHE_PERF_CNT_EN
                cnt_exp = {m_hit, m_miss, m_wb};
`else
                cnt_exp = '0;
`endif
                checks++;
                if (cnt_got !== cnt_exp) begin
                    failures++;
                    $display("FAIL counters cycle=%0d got=%h expected=%h", i, cnt_got, cnt_exp);
                end
                obs_ufp += int'(ufp_resp);
                obs_dr  += int'(dfp_read);
                obs_dw  += int'(dfp_write);
            end
            @(posedge clk);
            if (q[i].rst) begin
                m_hit = '0; m_miss = '0; m_wb = '0;
            end else begin
                m_hit  = sat_inc(m_hit, q[i].ih);
                m_miss = sat_inc(m_miss, q[i].im);
                m_wb   = sat_inc(m_wb, q[i].iw);
            end
            if (i == dir_end - 1) begin
                #1;
                // Hand-counted totals for the directed part of the run.
                checks++;
                if (obs_ufp != 6) begin
                    failures++; $display("FAIL directed_ufp_resp got=%0d expected=6", obs_ufp);
                end
                checks++;
                if (obs_dr != 7) begin
                    failures++; $display("FAIL directed_dfp_read got=%0d expected=7", obs_dr);
                end
                checks++;
                if (obs_dw != 3) begin
                    failures++; $display("FAIL directed_dfp_write got=%0d expected=3", obs_dw);
                end
`ifdef DCACHE_PERF_CNT_EN
                cnt_exp = {4'd4, 4'd2, 4'd1};
`else
                cnt_exp = '0;
`endif
                cnt_got = {hit_count, miss_count, writeback_count};
                checks++;
                if (cnt_got !== cnt_exp) begin
                    failures++;
                    $display("FAIL directed_counters got=%h expected=%h", cnt_got, cnt_exp);
                end
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
